avalon_st_pkt_gen: RTL and testbench

Avalon-ST packet source that drives the write side of `fifo` (or any Avalon-ST sink) with well-formed packets. On a `start` pulse it emits one packet of a requested byte length carrying an incrementing byte pattern, with correct `sop`/`eop`/`empty` framing and full `rdy` backpressure support. It is the transmitter counterpart to the fifo write interface and serves as a synthesizable stimulus source for fifo benches and bring-up.

---
 rtl/avalon_st_pkg.sv | 24 ++
 rtl/avalon_st_if.sv | 27 ++
 rtl/avalon_st_pkt_gen.sv | 148 ++++++++++++++
 tb/tb_avalon_st_pkt_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// rtl/avalon_st_pkg.sv - shared types and helpers for the Avalon-ST packet generator
//
// Contents:
//   state_t       generator FSM states (IDLE, SEND, GAP)
//   empty_width   width of the empty field: max(1, clog2(bytes per beat))
//   pattern_byte  payload byte k of a packet started at seed: (seed + k) mod 256
package avalon_st_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int empty_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  // Only the low 8 bits of the byte index matter since the pattern wraps mod 256.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] index);
    return seed + index;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// rtl/avalon_st_if.sv - Avalon-ST stream bundle with source/sink modports
//
// Signals:
//   data   8*DATA_WIDTH_IN_BYTES  payload, first byte in the most significant lane
//   vld    beat valid
//   sop    first beat of a packet
//   eop    last beat of a packet
//   empty  unused byte lanes on the eop beat
//   rdy    sink ready (transfer when vld && rdy)
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  import avalon_st_pkg::*;

  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             vld;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, vld, sop, eop, empty, input rdy);
  modport slave  (input data, vld, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_st_pkt_gen.sv
// rtl/avalon_st_pkt_gen.sv - Avalon-ST packet source with incrementing byte payload
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   start    one-cycle request to send a packet (accepted only in IDLE, pkt_len != 0)
//   pkt_len  packet length in bytes, sampled with start
//   seed     first payload byte, sampled with start
//   busy     high while a packet or the post-packet gap is in progress
//   pkt_cnt  completed packets, wraps mod 2^16
//   tx       stream source (data/vld/sop/eop/empty out, rdy in)
module avalon_st_pkt_gen
  import avalon_st_pkg::*;
#(
  parameter  int DATA_WIDTH_IN_BYTES = 4,
  parameter  int MAX_PKT_LEN_BYTES   = 256,
  parameter  int IDLE_GAP            = 0,
  localparam int LEN_W               = $clog2(MAX_PKT_LEN_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [7:0]       seed,
  output logic             busy,
  output logic [15:0]      pkt_cnt,
  avalon_st_if.master      tx
);

  localparam int DW      = DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = empty_width(DW);
  // Room for the start index of the beat after the last one plus a full beat.
  localparam int IDX_W   = $clog2(MAX_PKT_LEN_BYTES + 2 * DW + 1);
  localparam int GAP_W   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  state_t             state;
  logic [IDX_W-1:0]   len_q;
  logic [7:0]         seed_q;
  logic [IDX_W-1:0]   idx_q;   // packet byte index carried in the top lane of the current beat
  logic [GAP_W-1:0]   gap_q;

  // Next-beat builder. In IDLE it describes beat 0 of the requested packet from the
  // live inputs; otherwise it describes the beat following the one on the bus.
  logic [IDX_W-1:0]   b_len;
  logic [IDX_W-1:0]   b_idx;
  logic [7:0]         b_seed;
  logic [8*DW-1:0]    b_data;
  logic               b_eop;
  logic [EMPTY_W-1:0] b_empty;

  always_comb begin
    if (state == IDLE) begin
      b_len  = IDX_W'(pkt_len);
      b_seed = seed;
      b_idx  = '0;
    end else begin
      b_len  = len_q;
      b_seed = seed_q;
      b_idx  = idx_q + IDX_W'(DW);
    end

    b_data = '0;
    for (int lane = 0; lane < DW; lane++) begin
      if ((b_idx + IDX_W'(lane)) < b_len) begin
        b_data[8*(DW-1-lane) +: 8] = pattern_byte(b_seed, 8'(b_idx) + 8'(lane));
      end
    end

    b_eop   = (b_idx + IDX_W'(DW)) >= b_len;
    b_empty = b_eop ? EMPTY_W'(b_idx + IDX_W'(DW) - b_len) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pkt_cnt  <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      tx.vld   <= 1'b0;
      tx.sop   <= 1'b0;
      tx.eop   <= 1'b0;
      tx.data  <= '0;
      tx.empty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (pkt_len != '0)) begin
            len_q    <= b_len;
            seed_q   <= b_seed;
            idx_q    <= '0;
            tx.data  <= b_data;
            tx.sop   <= 1'b1;
            tx.eop   <= b_eop;
            tx.empty <= b_empty;
            tx.vld   <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end

        SEND: begin
          // Without rdy everything on the bus simply holds.
          if (tx.rdy) begin
            if (tx.eop) begin
              tx.vld   <= 1'b0;
              tx.sop   <= 1'b0;
              tx.eop   <= 1'b0;
              tx.data  <= '0;
              tx.empty <= '0;
              pkt_cnt  <= pkt_cnt + 16'd1;
              if (IDLE_GAP > 0) begin
                gap_q <= GAP_W'(IDLE_GAP - 1);
                state <= GAP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              idx_q    <= b_idx;
              tx.data  <= b_data;
              tx.sop   <= 1'b0;
              tx.eop   <= b_eop;
              tx.empty <= b_empty;
            end
          end
        end

        GAP: begin
          if (gap_q == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// tb/tb_avalon_st_pkt_gen.sv - scoreboard bench for avalon_st_pkt_gen
module tb_avalon_st_pkt_gen;
  import avalon_st_pkg::*;

  localparam int DW    = 4;
  localparam int MAXL  = 256;
  localparam int GAP_N = 3;
  localparam int LEN_W = $clog2(MAXL + 1);

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] pkt_len;
  logic [7:0]       seed;
  logic             busy;
  logic [15:0]      pkt_cnt;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) tx_if ();

  avalon_st_pkt_gen #(
    .DATA_WIDTH_IN_BYTES(DW),
    .MAX_PKT_LEN_BYTES  (MAXL),
    .IDLE_GAP           (GAP_N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .pkt_len(pkt_len),
    .seed   (seed),
    .busy   (busy),
    .pkt_cnt(pkt_cnt),
    .tx     (tx_if)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    exp_sent = 0;
  int    exp_cnt = 0;
  int    rdy_mode = 0;
  bit    hold_active = 0;
  beat_t sb_q[$];
  bit    rdy_pat[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: split the byte sequence (seed+k) mod 256 into DW-byte beats, top lane first.
  task automatic push_pkt(input int len, input logic [7:0] s);
    int    nb;
    int    k;
    beat_t e;
    nb = (len + DW - 1) / DW;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int l = 0; l < DW; l++) begin
        k = b * DW + l;
        if (k < len) e.data[8*(DW-1-l) +: 8] = 8'((int'(s) + k) % 256);
      end
      e.sop   = (b == 0);
      e.eop   = (b == nb - 1);
      e.empty = (b == nb - 1) ? 2'(nb * DW - len) : 2'd0;
      sb_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (rdy_pat.size() > 0) tx_if.rdy = rdy_pat.pop_front();
    else if (rdy_mode == 0) tx_if.rdy = 1'b1;
    else tx_if.rdy = ($urandom_range(0, 9) < 7);
  end

  // Monitor: samples at the falling edge, between driver updates and the active edge.
  beat_t       e_m;
  bit          cnt_chk = 0;
  bit          prev_stall = 0;
  bit          prev_vld = 0;
  bit          saw_eop = 0;
  int          eop_cyc = 0;
  logic [31:0] p_data;
  logic [3:0]  p_frm;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt    = 0;
      cnt_chk    = 0;
      prev_stall = 0;
      prev_vld   = 0;
      saw_eop    = 0;
    end else begin
      if (cnt_chk) begin
        check(pkt_cnt === 16'(exp_cnt), "pkt_cnt_after_eop", pkt_cnt, exp_cnt);
        cnt_chk = 0;
      end
      if (prev_stall) begin
        check(tx_if.vld === 1'b1 && tx_if.data === p_data &&
              {tx_if.sop, tx_if.eop, tx_if.empty} === p_frm,
              "hold_under_backpressure", {tx_if.vld, tx_if.sop, tx_if.eop, tx_if.empty, tx_if.data},
              {1'b1, p_frm, p_data});
      end
      if (tx_if.vld === 1'b1 && tx_if.sop === 1'b1 && !prev_vld && hold_active && saw_eop) begin
        check(cyc - eop_cyc == GAP_N + 2, "sop_spacing_edges", cyc - eop_cyc - 1, GAP_N + 1);
        saw_eop = 0;
      end
      if (tx_if.vld === 1'b1 && tx_if.eop === 1'b1 && tx_if.rdy !== 1'b1) begin
        check(pkt_cnt === 16'(exp_cnt), "pkt_cnt_before_eop_xfer", pkt_cnt, exp_cnt);
      end
      if (tx_if.vld === 1'b1 && tx_if.rdy === 1'b1) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_beat", tx_if.data, 0);
        end else begin
          e_m = sb_q.pop_front();
          check(tx_if.data === e_m.data, "beat_data", tx_if.data, e_m.data);
          check({tx_if.sop, tx_if.eop, tx_if.empty} === {e_m.sop, e_m.eop, e_m.empty},
                "beat_sop_eop_empty", {tx_if.sop, tx_if.eop, tx_if.empty}, {e_m.sop, e_m.eop, e_m.empty});
          if (e_m.eop) begin
            exp_cnt++;
            cnt_chk = 1;
            eop_cyc = cyc;
            if (hold_active) saw_eop = 1;
          end
        end
      end
      prev_stall = (tx_if.vld === 1'b1) && (tx_if.rdy !== 1'b1);
      prev_vld   = (tx_if.vld === 1'b1);
      p_data     = tx_if.data;
      p_frm      = {tx_if.sop, tx_if.eop, tx_if.empty};
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) check(1'b0, "wait_idle_timeout", busy, 0);
  endtask

  task automatic send(input int len, input logic [7:0] s, input bit accept);
    wait_idle();
    start   = 1'b1;
    pkt_len = LEN_W'(len);
    seed    = s;
    if (accept) begin
      push_pkt(len, s);
      exp_sent++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (accept)
      check(tx_if.vld === 1'b1 && tx_if.sop === 1'b1 && busy === 1'b1, "first_beat_latency",
            {tx_if.vld, tx_if.sop, busy}, 3'b111);
    else
      check(tx_if.vld === 1'b0 && busy === 1'b0, "zero_len_ignored", {tx_if.vld, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    start   = 1'b0;
    pkt_len = '0;
    seed    = '0;
    repeat (3) @(posedge clk);
    #1;
    check({tx_if.vld, tx_if.sop, tx_if.eop, busy} === 4'b0, "reset_flags",
          {tx_if.vld, tx_if.sop, tx_if.eop, busy}, 0);
    check(tx_if.data === 32'h0 && tx_if.empty === 2'd0, "reset_data_empty", {tx_if.data, tx_if.empty}, 0);
    check(pkt_cnt === 16'd0, "reset_pkt_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: three-beat packet with partial last beat, then a single full beat.
    rdy_mode = 0;
    send(10, 8'h00, 1);
    send(4, 8'hFE, 1);
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(t == 1 + GAP_N, "busy_cycles_len4", t, 1 + GAP_N);
    check(pkt_cnt === 16'd2, "pkt_cnt_two", pkt_cnt, 2);

    // Backpressure pattern on a 3-beat packet.
    send(12, 8'($urandom_range(0, 255)), 1);
    rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0);
    rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(1);
    wait_idle();

    // Zero length is ignored.
    send(0, 8'h12, 0);

    // start held high across two packets; re-requests while busy are ignored.
    wait_idle();
    hold_active = 1;
    push_pkt(8, 8'h33);
    push_pkt(8, 8'h33);
    exp_sent += 2;
    start   = 1'b1;
    pkt_len = LEN_W'(8);
    seed    = 8'h33;
    t = 0;
    while (pkt_cnt !== 16'(exp_sent - 1) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(pkt_cnt === 16'(exp_sent - 1), "hold_first_done", pkt_cnt, exp_sent - 1);
    t = 0;
    while (!(tx_if.vld === 1'b1 && tx_if.sop === 1'b1) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    wait_idle();
    hold_active = 0;
    check(pkt_cnt === 16'(exp_sent), "hold_pkt_cnt", pkt_cnt, exp_sent);

    // Asynchronous reset in the middle of a 5-beat packet.
    send(20, 8'h5A, 1);
    t = 0;
    while (sb_q.size() > 3 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check({tx_if.vld, tx_if.sop, tx_if.eop, busy} === 4'b0, "async_reset_flags",
          {tx_if.vld, tx_if.sop, tx_if.eop, busy}, 0);
    check(pkt_cnt === 16'd0, "async_reset_pkt_cnt", pkt_cnt, 0);
    exp_sent = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4, 8'h77, 1);
    wait_idle();
    check(pkt_cnt === 16'd1, "post_reset_pkt_cnt", pkt_cnt, 1);

    // Randomised lengths, seeds and backpressure, with stray start pulses while busy.
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      send($urandom_range(1, MAXL), 8'($urandom_range(0, 255)), 1);
      if ($urandom_range(0, 1) == 1) begin
        start   = 1'b1;
        pkt_len = LEN_W'($urandom_range(1, MAXL));
        @(posedge clk); #1;
        start = 1'b0;
      end
    end

    rdy_mode = 0;
    wait_idle();
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
    check(pkt_cnt === 16'(exp_sent), "final_pkt_cnt", pkt_cnt, exp_sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
